// File: rtl/cpu_id_rs_if.sv
// cpu_id_rs_if: port bundle between the front end (instruction memory / PC)
// and the cpu_id_rs decoder.
//
// Handshake: there is no back-pressure. A word on IN is taken on the rising
// clock edge when IN_VALID=1 and FLUSH=0. Anything else is a bubble. OUT_VALID
// marks the registered outputs as a decoded instruction for exactly one cycle
// after the edge that took it.
//
// master : front end. Drives IN, IN_VALID, FLUSH and PC. Receives the decoded
//          strobes and fields.
// slave  : decoder. Receives the instruction and drives the decoded outputs.
interface cpu_id_rs_if #(
  parameter int WIDTH          = 13,
  parameter int IWIDTH         = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int PC_WIDTH       = 8,
  parameter int RS_DEPTH       = 4
);
  localparam int OW = WIDTH - IWIDTH;
  localparam int CW = $clog2(RS_DEPTH + 1);

  logic [WIDTH-1:0]          IN;
  logic                      IN_VALID;
  logic                      FLUSH;
  logic [PC_WIDTH-1:0]       PC;

  logic                      PC_RST;
  logic                      PC_LD;
  logic                      EN_REG_F;
  logic                      EN_D_MEM;
  logic                      EN_ACC;
  logic                      BASE_REG_LD;
  logic                      D_MEM_ADDR_MODE;
  logic [IWIDTH-2:0]         ALU_OUT;
  logic [OW-1:0]             IMM;
  logic [OW-1:0]             D_MEM_ADDR;
  logic [OW-1:0]             BASE_REG_OFFSET;
  logic [OW-1:0]             BASE_REG_DATA;
  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL;
  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
  logic [1:0]                JMP_MODE;
  logic [PC_WIDTH-1:0]       RET_ADDR;
  logic                      OUT_VALID;
  logic [CW-1:0]             RS_COUNT;
  logic                      RS_FULL;
  logic                      RS_EMPTY;
  logic                      STACK_ERR;

  modport master (
    output IN, IN_VALID, FLUSH, PC,
    input  PC_RST, PC_LD, EN_REG_F, EN_D_MEM, EN_ACC, BASE_REG_LD,
           D_MEM_ADDR_MODE, ALU_OUT, IMM, D_MEM_ADDR, BASE_REG_OFFSET,
           BASE_REG_DATA, IN_B_SEL, REG_F_SEL, JMP_MODE, RET_ADDR, OUT_VALID,
           RS_COUNT, RS_FULL, RS_EMPTY, STACK_ERR
  );

  modport slave (
    input  IN, IN_VALID, FLUSH, PC,
    output PC_RST, PC_LD, EN_REG_F, EN_D_MEM, EN_ACC, BASE_REG_LD,
           D_MEM_ADDR_MODE, ALU_OUT, IMM, D_MEM_ADDR, BASE_REG_OFFSET,
           BASE_REG_DATA, IN_B_SEL, REG_F_SEL, JMP_MODE, RET_ADDR, OUT_VALID,
           RS_COUNT, RS_FULL, RS_EMPTY, STACK_ERR
  );
endinterface

// File: rtl/cpu_id_rs.sv
// cpu_id_rs: registered instruction decoder with a hardware return-address
// stack.
//
// The decoder takes one instruction per clock and turns it into datapath
// control strobes and operand fields. The outputs are registered, so they
// appear one cycle after the instruction.
//
// CALL pushes PC+1 onto an internal LIFO. RET pops that LIFO. This lets calls
// nest up to RS_DEPTH deep.
//
// Ports:
//   CLK - clock, rising edge.
//   RST - synchronous, active-high reset.
//   bus - cpu_id_rs_if.slave:
//         inputs  : IN, IN_VALID, FLUSH, PC
//         outputs : the decoded strobes and fields, RET_ADDR, OUT_VALID,
//                   RS_COUNT, RS_FULL, RS_EMPTY, STACK_ERR
//
// Opcode map (IN[WIDTH-1:OW]):
//   0 RST    1 LD     2 ST     3 LDR    4 STR    5 BAR    6 LDI
//   7 LDAR   8 JMP    9 JMPO  10 XORR  11 ORR   12 ANDR  13 ADDR
//  14 SUBR  15 CALL  16 RET
// All other opcodes are undefined. They decode to the default field values.
module cpu_id_rs #(
  parameter int WIDTH          = 13,
  parameter int IWIDTH         = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int PC_WIDTH       = 8,
  parameter int RS_DEPTH       = 4
) (
  input logic        CLK,
  input logic        RST,
  cpu_id_rs_if.slave bus
);
  localparam int OW = WIDTH - IWIDTH;
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  localparam logic [IWIDTH-1:0] OP_RST  = IWIDTH'(0);
  localparam logic [IWIDTH-1:0] OP_LD   = IWIDTH'(1);
  localparam logic [IWIDTH-1:0] OP_ST   = IWIDTH'(2);
  localparam logic [IWIDTH-1:0] OP_LDR  = IWIDTH'(3);
  localparam logic [IWIDTH-1:0] OP_STR  = IWIDTH'(4);
  localparam logic [IWIDTH-1:0] OP_BAR  = IWIDTH'(5);
  localparam logic [IWIDTH-1:0] OP_LDI  = IWIDTH'(6);
  localparam logic [IWIDTH-1:0] OP_LDAR = IWIDTH'(7);
  localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'(8);
  localparam logic [IWIDTH-1:0] OP_JMPO = IWIDTH'(9);
  localparam logic [IWIDTH-1:0] OP_XORR = IWIDTH'(10);
  localparam logic [IWIDTH-1:0] OP_ORR  = IWIDTH'(11);
  localparam logic [IWIDTH-1:0] OP_ANDR = IWIDTH'(12);
  localparam logic [IWIDTH-1:0] OP_ADDR = IWIDTH'(13);
  localparam logic [IWIDTH-1:0] OP_SUBR = IWIDTH'(14);
  localparam logic [IWIDTH-1:0] OP_CALL = IWIDTH'(15);
  localparam logic [IWIDTH-1:0] OP_RET  = IWIDTH'(16);

  localparam logic [IN_B_SEL_SIZE-1:0] B_IMM = IN_B_SEL_SIZE'(0);
  localparam logic [IN_B_SEL_SIZE-1:0] B_REG = IN_B_SEL_SIZE'(1);
  localparam logic [IN_B_SEL_SIZE-1:0] B_MEM = IN_B_SEL_SIZE'(2);

  typedef struct packed {
    logic                      pc_rst;
    logic                      pc_ld;
    logic                      en_reg_f;
    logic                      en_d_mem;
    logic                      en_acc;
    logic                      base_reg_ld;
    logic                      d_mem_addr_mode;
    logic [IWIDTH-2:0]         alu_out;
    logic [OW-1:0]             imm;
    logic [OW-1:0]             d_mem_addr;
    logic [OW-1:0]             base_reg_offset;
    logic [OW-1:0]             base_reg_data;
    logic [IN_B_SEL_SIZE-1:0]  in_b_sel;
    logic [REG_F_SEL_SIZE-1:0] reg_f_sel;
    logic [1:0]                jmp_mode;
    logic [PC_WIDTH-1:0]       ret_addr;
    logic                      out_valid;
  } dec_t;

  dec_t                d;
  dec_t                q;
  logic [PC_WIDTH-1:0] rs_mem [RS_DEPTH];
  logic [CW-1:0]       rs_count;
  logic                stack_err;
  logic                do_push;
  logic                do_pop;
  logic                clr_stack;
  logic                set_err;

  logic [IWIDTH-1:0]   opcode;
  logic [OW-1:0]       operand;
  logic                accept;
  logic                rs_full;
  logic                rs_empty;
  logic [IW-1:0]       top_idx;
  logic [IW-1:0]       push_idx;

  assign opcode   = bus.IN[WIDTH-1:OW];
  assign operand  = bus.IN[OW-1:0];
  assign accept   = bus.IN_VALID && !bus.FLUSH;
  assign rs_full  = (rs_count == CW'(RS_DEPTH));
  assign rs_empty = (rs_count == '0);
  assign top_idx  = IW'(rs_count - CW'(1));
  assign push_idx = IW'(rs_count);

  always_comb begin
    d           = '0;
    d.in_b_sel  = B_MEM;
    d.alu_out   = bus.IN[WIDTH-2:OW];
    do_push     = 1'b0;
    do_pop      = 1'b0;
    clr_stack   = 1'b0;
    set_err     = 1'b0;
    if (accept) begin
      d.out_valid = 1'b1;
      case (opcode)
        OP_RST: begin
          d.pc_rst  = 1'b1;
          clr_stack = 1'b1;
        end
        OP_LD: begin
          d.d_mem_addr = operand;
          d.en_acc     = 1'b1;
        end
        OP_ST: begin
          d.d_mem_addr = operand;
          d.en_d_mem   = 1'b1;
        end
        OP_LDR: begin
          d.reg_f_sel = bus.IN[REG_F_SEL_SIZE-1:0];
          d.in_b_sel  = B_REG;
          d.en_acc    = 1'b1;
        end
        OP_STR: begin
          d.reg_f_sel = bus.IN[REG_F_SEL_SIZE-1:0];
          d.en_reg_f  = 1'b1;
        end
        OP_BAR: begin
          d.base_reg_data = operand;
          d.base_reg_ld   = 1'b1;
        end
        OP_LDI: begin
          d.imm      = operand;
          d.in_b_sel = B_IMM;
          d.en_acc   = 1'b1;
        end
        OP_LDAR: begin
          d.reg_f_sel       = bus.IN[REG_F_SEL_SIZE-1:0];
          d.d_mem_addr_mode = 1'b1;
          d.en_acc          = 1'b1;
        end
        OP_JMP, OP_JMPO: begin
          d.base_reg_offset = operand;
          d.jmp_mode        = (opcode == OP_JMPO) ? 2'b01 : 2'b00;
          d.pc_ld           = 1'b1;
        end
        OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR: begin
          d.reg_f_sel = bus.IN[REG_F_SEL_SIZE-1:0];
          d.in_b_sel  = B_REG;
        end
        OP_CALL: begin
          // A CALL on a full stack degrades to a NOP so that the PC keeps
          // running sequentially. The error is left for software to notice.
          if (rs_full) begin
            set_err = 1'b1;
          end else begin
            do_push           = 1'b1;
            d.base_reg_offset = operand;
            d.pc_ld           = 1'b1;
          end
        end
        OP_RET: begin
          if (rs_empty) begin
            set_err = 1'b1;
          end else begin
            do_pop     = 1'b1;
            d.ret_addr = rs_mem[top_idx];
            d.jmp_mode = 2'b11;
            d.pc_ld    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q          <= '0;
      q.in_b_sel <= B_MEM;
      rs_count   <= '0;
      stack_err  <= 1'b0;
    end else begin
      q <= d;
      if (clr_stack) begin
        rs_count <= '0;
      end else if (do_push) begin
        rs_count <= rs_count + CW'(1);
      end else if (do_pop) begin
        rs_count <= rs_count - CW'(1);
      end
      if (clr_stack) begin
        stack_err <= 1'b0;
      end else if (set_err) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Stack contents carry no reset. Only rs_count decides which entries are
  // live. Adding PC_WIDTH'(1) drops the carry, so a CALL at the top of the
  // address space pushes address 0.
  always_ff @(posedge CLK) begin
    if (!RST && do_push) begin
      rs_mem[push_idx] <= bus.PC + PC_WIDTH'(1);
    end
  end

  assign bus.PC_RST          = q.pc_rst;
  assign bus.PC_LD           = q.pc_ld;
  assign bus.EN_REG_F        = q.en_reg_f;
  assign bus.EN_D_MEM        = q.en_d_mem;
  assign bus.EN_ACC          = q.en_acc;
  assign bus.BASE_REG_LD     = q.base_reg_ld;
  assign bus.D_MEM_ADDR_MODE = q.d_mem_addr_mode;
  assign bus.ALU_OUT         = q.alu_out;
  assign bus.IMM             = q.imm;
  assign bus.D_MEM_ADDR      = q.d_mem_addr;
  assign bus.BASE_REG_OFFSET = q.base_reg_offset;
  assign bus.BASE_REG_DATA   = q.base_reg_data;
  assign bus.IN_B_SEL        = q.in_b_sel;
  assign bus.REG_F_SEL       = q.reg_f_sel;
  assign bus.JMP_MODE        = q.jmp_mode;
  assign bus.RET_ADDR        = q.ret_addr;
  assign bus.OUT_VALID       = q.out_valid;
  assign bus.RS_COUNT        = rs_count;
  assign bus.RS_FULL         = rs_full;
  assign bus.RS_EMPTY        = rs_empty;
  assign bus.STACK_ERR       = stack_err;
endmodule

// File: tb/tb_cpu_id_rs.sv
// tb_cpu_id_rs: self-checking bench for cpu_id_rs with the default parameters.
//
// Each applied vector carries its inputs plus hand-derived key outputs:
// PC_LD, JMP_MODE, RET_ADDR, RS_COUNT and STACK_ERR. A reference model also
// builds the full expected output vector. That vector is queued when the
// inputs are driven, and compared one clock later.
module tb_cpu_id_rs;
  localparam int OP_RST  = 0;
  localparam int OP_LD   = 1;
  localparam int OP_ST   = 2;
  localparam int OP_LDR  = 3;
  localparam int OP_STR  = 4;
  localparam int OP_BAR  = 5;
  localparam int OP_LDI  = 6;
  localparam int OP_LDAR = 7;
  localparam int OP_JMP  = 8;
  localparam int OP_JMPO = 9;
  localparam int OP_XORR = 10;
  localparam int OP_ORR  = 11;
  localparam int OP_ANDR = 12;
  localparam int OP_ADDR = 13;
  localparam int OP_SUBR = 14;
  localparam int OP_CALL = 15;
  localparam int OP_RET  = 16;
  localparam int OP_UNDF = 31;
  localparam int DEPTH   = 4;

  typedef struct {
    int rst;
    int valid;
    int flush;
    int op;
    int opnd;
    int pc;
    int e_pc_ld;
    int e_jmp;
    int e_ret;
    int e_cnt;
    int e_err;
  } vec_t;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_id_rs_if bus ();
  cpu_id_rs dut (.CLK(clk), .RST(rst), .bus(bus));

  initial begin
    bus.IN       = '0;
    bus.IN_VALID = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.PC       = '0;
  end

  int          n_total = 0;
  int          n_bad   = 0;
  logic [65:0] exp_q[$];
  int          m_stack[$];
  int          m_err = 0;
  vec_t        dec_tab[$];

  function automatic vec_t mk(input int r, input int va, input int fl, input int op,
                              input int opnd, input int pc, input int pcld,
                              input int jm, input int ra, input int cnt, input int err);
    vec_t v;
    v.rst = r; v.valid = va; v.flush = fl; v.op = op; v.opnd = opnd; v.pc = pc;
    v.e_pc_ld = pcld; v.e_jmp = jm; v.e_ret = ra; v.e_cnt = cnt; v.e_err = err;
    return v;
  endfunction

  function automatic logic [65:0] dut_vec();
    return {bus.PC_RST, bus.PC_LD, bus.EN_REG_F, bus.EN_D_MEM, bus.EN_ACC,
            bus.BASE_REG_LD, bus.D_MEM_ADDR_MODE, bus.ALU_OUT, bus.IMM,
            bus.D_MEM_ADDR, bus.BASE_REG_OFFSET, bus.BASE_REG_DATA, bus.IN_B_SEL,
            bus.REG_F_SEL, bus.JMP_MODE, bus.RET_ADDR, bus.OUT_VALID,
            bus.RS_COUNT, bus.RS_FULL, bus.RS_EMPTY, bus.STACK_ERR};
  endfunction

  // Reference model: one call per clock. It updates the model stack and
  // returns the full output vector that should appear after the edge.
  task automatic model_step(input vec_t v, output logic [65:0] e);
    logic       pc_rst, pc_ld, en_rf, en_dm, en_acc, brl, dmm, ov;
    logic [3:0] alu, rsel;
    logic [7:0] imm, dma, boff, bdata, ret;
    logic [1:0] bsel, jmp;
    pc_rst = 0; pc_ld = 0; en_rf = 0; en_dm = 0; en_acc = 0; brl = 0; dmm = 0; ov = 0;
    imm = 0; dma = 0; boff = 0; bdata = 0; ret = 0; rsel = 0; jmp = 0;
    bsel = 2'b10;
    alu  = 4'(v.op);
    if (v.rst != 0) begin
      m_stack.delete();
      m_err = 0;
      alu = 4'h0;
    end else if (v.valid != 0 && v.flush == 0) begin
      ov = 1;
      case (v.op)
        OP_RST:  begin pc_rst = 1; m_stack.delete(); m_err = 0; end
        OP_LD:   begin dma = 8'(v.opnd); en_acc = 1; end
        OP_ST:   begin dma = 8'(v.opnd); en_dm = 1; end
        OP_LDR:  begin rsel = 4'(v.opnd); bsel = 2'b01; en_acc = 1; end
        OP_STR:  begin rsel = 4'(v.opnd); en_rf = 1; end
        OP_BAR:  begin bdata = 8'(v.opnd); brl = 1; end
        OP_LDI:  begin imm = 8'(v.opnd); bsel = 2'b00; en_acc = 1; end
        OP_LDAR: begin rsel = 4'(v.opnd); dmm = 1; en_acc = 1; end
        OP_JMP:  begin boff = 8'(v.opnd); pc_ld = 1; end
        OP_JMPO: begin boff = 8'(v.opnd); jmp = 2'b01; pc_ld = 1; end
        OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR: begin
          rsel = 4'(v.opnd); bsel = 2'b01;
        end
        OP_CALL: begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back((v.pc + 1) % 256);
            boff = 8'(v.opnd); pc_ld = 1;
          end else begin
            m_err = 1;
          end
        end
        OP_RET: begin
          if (m_stack.size() > 0) begin
            ret = 8'(m_stack.pop_back()); jmp = 2'b11; pc_ld = 1;
          end else begin
            m_err = 1;
          end
        end
        default: ;
      endcase
    end
    e = {pc_rst, pc_ld, en_rf, en_dm, en_acc, brl, dmm, alu, imm, dma, boff, bdata,
         bsel, rsel, jmp, ret, ov, 3'(m_stack.size()), m_stack.size() == DEPTH,
         m_stack.size() == 0, 1'(m_err)};
  endtask

  // Driver plus scoreboard. Inputs are driven on the falling edge and the
  // outputs are sampled 1 ns after the rising edge that registers them.
  task automatic apply(input string name, input vec_t v);
    logic [65:0] e, got, x;
    @(negedge clk);
    rst          = 1'(v.rst);
    bus.IN_VALID = 1'(v.valid);
    bus.FLUSH    = 1'(v.flush);
    bus.IN       = {5'(v.op), 8'(v.opnd)};
    bus.PC       = 8'(v.pc);
    model_step(v, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = dut_vec();
    n_total++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      x = exp_q.pop_front();
      if (got !== x) begin
        n_bad++;
        $display("FAIL %s outputs got=%h exp=%h", name, got, x);
      end
    end
    n_total++;
    if (int'(bus.PC_LD) != v.e_pc_ld || int'(bus.JMP_MODE) != v.e_jmp ||
        int'(bus.RET_ADDR) != v.e_ret || int'(bus.RS_COUNT) != v.e_cnt ||
        int'(bus.STACK_ERR) != v.e_err || ^dut_vec() === 1'bx) begin
      n_bad++;
      $display("FAIL %s key got pc_ld=%0d jmp=%0d ret=%h cnt=%0d err=%0d exp pc_ld=%0d jmp=%0d ret=%h cnt=%0d err=%0d",
               name, bus.PC_LD, bus.JMP_MODE, bus.RET_ADDR, bus.RS_COUNT, bus.STACK_ERR,
               v.e_pc_ld, v.e_jmp, v.e_ret, v.e_cnt, v.e_err);
    end
  endtask

  initial begin
    // Single-cycle decode table: key fields stay at zero except for the jumps.
    dec_tab.push_back(mk(0, 1, 0, OP_LDI,  'h5A, 'h00, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_LDR,  'h03, 'h01, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_LD,   'h12, 'h02, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_ST,   'h34, 'h03, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_STR,  'h05, 'h04, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_BAR,  'h77, 'h05, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_LDAR, 'h02, 'h06, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_JMP,  'h44, 'h07, 1, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_JMPO, 'h45, 'h08, 1, 1, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_XORR, 'h01, 'h09, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_ORR,  'h02, 'h0A, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_ANDR, 'h0B, 'h0B, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_ADDR, 'h06, 'h0C, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_SUBR, 'h07, 'h0D, 0, 0, 0, 0, 0));
    dec_tab.push_back(mk(0, 1, 0, OP_UNDF, 'hAB, 'h0E, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      dec_tab.push_back(mk(0, 1, 0, int'($urandom_range(1, 7)), int'($urandom_range(0, 255)),
                           'h0F, 0, 0, 0, 0, 0));
    end

    // Reset held two cycles with a CALL presented on IN.
    apply("reset0", mk(1, 1, 0, OP_CALL, 'h00, 'h40, 0, 0, 0, 0, 0));
    apply("reset1", mk(1, 1, 0, OP_CALL, 'h00, 'h40, 0, 0, 0, 0, 0));

    foreach (dec_tab[i]) apply($sformatf("dec%0d", i), dec_tab[i]);

    // Nesting: three calls, then three returns in reverse order.
    apply("nest_call0", mk(0, 1, 0, OP_CALL, 'h80, 'h10, 1, 0, 'h00, 1, 0));
    apply("nest_call1", mk(0, 1, 0, OP_CALL, 'h90, 'h20, 1, 0, 'h00, 2, 0));
    apply("nest_call2", mk(0, 1, 0, OP_CALL, 'hA0, 'h30, 1, 0, 'h00, 3, 0));
    apply("nest_ret0",  mk(0, 1, 0, OP_RET,  'h00, 'hA0, 1, 3, 'h31, 2, 0));
    apply("nest_ret1",  mk(0, 1, 0, OP_RET,  'h00, 'h31, 1, 3, 'h21, 1, 0));
    apply("nest_ret2",  mk(0, 1, 0, OP_RET,  'h00, 'h21, 1, 3, 'h11, 0, 0));

    // Overflow: one CALL too many is a NOP and sets the sticky error.
    for (int i = 1; i <= DEPTH; i++)
      apply($sformatf("ovf_call%0d", i), mk(0, 1, 0, OP_CALL, 'h40, i, 1, 0, 0, i, 0));
    apply("ovf_extra", mk(0, 1, 0, OP_CALL, 'h40, 'h05, 0, 0, 0, DEPTH, 1));
    for (int i = DEPTH; i >= 1; i--)
      apply($sformatf("ovf_ret%0d", i), mk(0, 1, 0, OP_RET, 0, 'h50, 1, 3, i + 1, i - 1, 1));
    apply("underflow", mk(0, 1, 0, OP_RET, 'h00, 'h51, 0, 0, 0, 0, 1));
    apply("err_sticky", mk(0, 1, 0, OP_LDI, 'h11, 'h52, 0, 0, 0, 0, 1));
    apply("rst_op", mk(0, 1, 0, OP_RST, 'h00, 'h53, 0, 0, 0, 0, 0));

    // Flushes and bubbles leave the stack alone.
    apply("flush_call",  mk(0, 1, 1, OP_CALL, 'h20, 'h50, 0, 0, 0, 0, 0));
    apply("bubble_call", mk(0, 0, 0, OP_CALL, 'h20, 'h50, 0, 0, 0, 0, 0));
    apply("live_call",   mk(0, 1, 0, OP_CALL, 'h20, 'h60, 1, 0, 0, 1, 0));
    apply("flush_ret",   mk(0, 1, 1, OP_RET,  'h00, 'h20, 0, 0, 0, 1, 0));
    apply("bubble_ret",  mk(0, 0, 0, OP_RET,  'h00, 'h20, 0, 0, 0, 1, 0));
    apply("live_ret",    mk(0, 1, 0, OP_RET,  'h00, 'h20, 1, 3, 'h61, 0, 0));

    // Return address wraps from the top of the address space to 0.
    apply("wrap_call", mk(0, 1, 0, OP_CALL, 'h33, 'hFF, 1, 0, 0, 1, 0));
    apply("wrap_ret",  mk(0, 1, 0, OP_RET,  'h00, 'h33, 1, 3, 'h00, 0, 0));

    // Reset port in the middle of a nest discards every entry.
    apply("mid_call0", mk(0, 1, 0, OP_CALL, 'h10, 'h08, 1, 0, 0, 1, 0));
    apply("mid_call1", mk(0, 1, 0, OP_CALL, 'h10, 'h09, 1, 0, 0, 2, 0));
    apply("mid_rst",   mk(1, 1, 1, OP_CALL, 'h10, 'h0A, 0, 0, 0, 0, 0));
    apply("mid_ret",   mk(0, 1, 0, OP_RET,  'h00, 'h0B, 0, 0, 0, 0, 1));
    apply("end_rst",   mk(1, 0, 0, OP_RST,  'h00, 'h00, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
